// File: rtl/rcu_pll_seq_if.sv
// Reconfiguration request handshake between a requester and rcu_pll_seq.
// The requester drives valid/cfg and the sequencer returns ready.
interface rcu_pll_seq_if #(
   parameter int CFG_WIDTH = 3
);
   logic                 req_valid_i;
   logic                 req_ready_o;
   logic [CFG_WIDTH-1:0] req_cfg_i;

   modport master (
      output req_valid_i,
      output req_cfg_i,
      input  req_ready_o
   );

   modport slave (
      input  req_valid_i,
      input  req_cfg_i,
      output req_ready_o
   );
endinterface

// File: rtl/rcu_pll_seq.sv
// PLL reconfiguration sequencer: gate, bypass, program, wait lock, switch.
// Also falls back to the bypass clock when lock drops while running on the PLL.
module rcu_pll_seq #(
   parameter int                   CFG_WIDTH   = 3,
   parameter logic [CFG_WIDTH-1:0] RESET_CFG   = 0,
   parameter int                   SETTLE_CYC  = 4,
   parameter int                   LOCK_STABLE = 8,
   parameter int                   TIMEOUT_CYC = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   rcu_pll_seq_if.slave         req,
   output logic [CFG_WIDTH-1:0] pll_cfg_o,
   input  logic                 pll_lock_i,
   output logic                 sel_pll_o,
   output logic                 clk_gate_en_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam int SCW = $clog2(2*SETTLE_CYC+1);
   localparam int STW = $clog2(LOCK_STABLE+1);
   localparam int TOW = $clog2(TIMEOUT_CYC+1);

   localparam logic [SCW-1:0] S_LAST = SCW'(SETTLE_CYC-1);
   localparam logic [SCW-1:0] F_LAST = SCW'(2*SETTLE_CYC-1);
   localparam logic [SCW-1:0] S_MAX  = SCW'(2*SETTLE_CYC);
   localparam logic [STW-1:0] ST_MAX = STW'(LOCK_STABLE);
   localparam logic [TOW-1:0] TO_MAX = TOW'(TIMEOUT_CYC);

   typedef enum logic [3:0] {
      IDLE, GATE_OFF, BYPASS, PROG, WAIT_LOCK,
      SWITCH, GATE_ON, FAIL, FALLBACK
   } state_t;

   state_t               state_q, state_d;
   logic [SCW-1:0]       cnt_q, cnt_d, cnt_inc;
   logic [STW-1:0]       stb_q, stb_d, stb_inc;
   logic [TOW-1:0]       tmo_q, tmo_d, tmo_inc;
   logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
   logic [CFG_WIDTH-1:0] pll_q, pll_d;
   logic                 sel_q, sel_d;
   logic                 gate_q, gate_d;
   logic                 err_q, err_d;
   logic                 done_q, done_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic [1:0]           sync_q;
   logic                 lock_s;

   assign lock_s = sync_q[1];

   assign cnt_inc = (cnt_q == S_MAX)  ? cnt_q : cnt_q + 1'b1;
   assign stb_inc = (stb_q == ST_MAX) ? stb_q : stb_q + 1'b1;
   assign tmo_inc = (tmo_q == TO_MAX) ? tmo_q : tmo_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_inc;
      stb_d   = stb_q;
      tmo_d   = tmo_q;
      cfg_d   = cfg_q;
      pll_d   = pll_q;
      sel_d   = sel_q;
      gate_d  = gate_q;
      err_d   = err_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            // Lock loss outranks a request arriving on the same edge
            if (sel_q && !lock_s) begin
               state_d = FALLBACK;
               gate_d  = 1'b0;
               err_d   = 1'b1;
            end else if (req.req_valid_i && ready_q) begin
               state_d = GATE_OFF;
               cfg_d   = req.req_cfg_i;
               gate_d  = 1'b0;
            end
         end
         GATE_OFF: begin
            if (cnt_q == S_LAST) begin
               state_d = BYPASS;
               cnt_d   = '0;
               sel_d   = 1'b0;
            end
         end
         BYPASS: begin
            if (cnt_q == S_LAST) begin
               state_d = PROG;
               cnt_d   = '0;
               pll_d   = cfg_q;
            end
         end
         PROG: begin
            state_d = WAIT_LOCK;
            stb_d   = '0;
            tmo_d   = '0;
         end
         WAIT_LOCK: begin
            stb_d = lock_s ? stb_inc : '0;
            tmo_d = tmo_inc;
            if (stb_d == ST_MAX) begin
               state_d = SWITCH;
               cnt_d   = '0;
               sel_d   = 1'b1;
            end else if (tmo_d == TO_MAX) begin
               state_d = FAIL;
               sel_d   = 1'b0;
               gate_d  = 1'b1;
               err_d   = 1'b1;
               done_d  = 1'b1;
            end
         end
         SWITCH: begin
            if (cnt_q == S_LAST) begin
               state_d = GATE_ON;
               gate_d  = 1'b1;
               done_d  = 1'b1;
               err_d   = 1'b0;
            end
         end
         GATE_ON:  state_d = IDLE;
         FAIL:     state_d = IDLE;
         FALLBACK: begin
            // First half settles the gate, second half the mux
            if (cnt_q == S_LAST) sel_d = 1'b0;
            if (cnt_q == F_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               gate_d  = 1'b1;
            end
         end
         default:  state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         stb_q   <= '0;
         tmo_q   <= '0;
         cfg_q   <= RESET_CFG;
         pll_q   <= RESET_CFG;
         sel_q   <= 1'b0;
         gate_q  <= 1'b1;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stb_q   <= stb_d;
         tmo_q   <= tmo_d;
         cfg_q   <= cfg_d;
         pll_q   <= pll_d;
         sel_q   <= sel_d;
         gate_q  <= gate_d;
         err_q   <= err_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         sync_q  <= {sync_q[0], pll_lock_i};
      end
   end

   assign req.req_ready_o = ready_q;
   assign pll_cfg_o       = pll_q;
   assign sel_pll_o       = sel_q;
   assign clk_gate_en_o   = gate_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign err_o           = err_q;

endmodule

// File: tb/tb_rcu_pll_seq.sv
// Bench for rcu_pll_seq: output edges are matched against a queue of
// expected {signal, value, cycle} events built from the sequence timing.
module tb_rcu_pll_seq;
   localparam int S = 4;
   localparam int L = 8;
   localparam int T = 1024;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lock = 1'b0;
   logic [2:0] cfg_o;
   logic       sel, gate, busy, done, err;
   logic       p_gate, p_sel, p_done, p_err;
   logic [2:0] p_cfg;
   logic       mon_en = 1'b0;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   logic [31:0] expq[$];

   rcu_pll_seq_if #(.CFG_WIDTH(3)) rif();

   rcu_pll_seq #(
      .CFG_WIDTH(3), .RESET_CFG(3'd0), .SETTLE_CYC(S),
      .LOCK_STABLE(L), .TIMEOUT_CYC(T)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .req(rif.slave),
      .pll_cfg_o(cfg_o), .pll_lock_i(lock), .sel_pll_o(sel),
      .clk_gate_en_o(gate), .busy_o(busy), .done_o(done), .err_o(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ev(int s, int v, int c);
      return {s[3:0], v[3:0], c[23:0]};
   endfunction

   task automatic push(int s, int v, int c);
      expq.push_back(ev(s, v, c));
   endtask

   task automatic see(int s, int v);
      if (expq.size() == 0) chk("extra_event", ev(s, v, cyc), 32'd0);
      else chk("event", ev(s, v, cyc), expq.pop_front());
   endtask

   // Signal ids: 1 gate, 2 sel, 3 cfg, 4 done, 5 err
   always @(negedge clk) begin
      if (mon_en) begin
         if (gate !== p_gate) see(1, int'(gate));
         if (sel !== p_sel) see(2, int'(sel));
         if (cfg_o !== p_cfg) see(3, int'(cfg_o));
         if (done !== p_done) see(4, int'(done));
         if (err !== p_err) see(5, int'(err));
      end
      p_gate <= gate;
      p_sel  <= sel;
      p_cfg  <= cfg_o;
      p_done <= done;
      p_err  <= err;
   end

   task automatic wait_cyc(int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_cfg"}, cfg_o, 0);
      chk({tag, "_sel"}, sel, 0);
      chk({tag, "_gate"}, gate, 1);
      chk({tag, "_rdy"}, rif.req_ready_o, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   initial begin
      int a, c, f, a3, t;
      rif.req_valid_i = 1'b0;
      rif.req_cfg_i   = 3'd0;
      repeat (2) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      // Nominal sequence to cfg 5 with lock held high
      lock = 1'b1;
      a = cyc + 1;
      rif.req_valid_i = 1'b1;
      rif.req_cfg_i   = 3'd5;
      push(1, 0, a);
      push(3, 5, a + 2*S);
      push(2, 1, a + 2*S + 1 + L);
      push(1, 1, a + 3*S + 1 + L);
      push(4, 1, a + 3*S + 1 + L);
      push(4, 0, a + 3*S + 2 + L);
      @(negedge clk);
      rif.req_valid_i = 1'b0;
      chk("nom_rdy", rif.req_ready_o, 0);
      chk("nom_busy", busy, 1);
      wait_cyc(a + 3*S + L + 5);
      chk("nom_pend", expq.size(), 0);
      chk("nom_sel", sel, 1);
      chk("nom_err", err, 0);

      // Lock loss in IDLE; request appears on the fallback edge and stays
      c = cyc;
      lock = 1'b0;
      f = c + 3;
      wait_cyc(c + 2);
      rif.req_valid_i = 1'b1;
      rif.req_cfg_i   = 3'd3;
      push(1, 0, f);
      push(5, 1, f);
      push(2, 0, f + S);
      push(1, 1, f + 2*S);
      a = f + 2*S + 1;
      push(1, 0, a);
      push(3, 3, a + 2*S);
      push(2, 1, a + 2*S + 1 + L);
      push(1, 1, a + 3*S + 1 + L);
      push(4, 1, a + 3*S + 1 + L);
      push(5, 0, a + 3*S + 1 + L);
      push(4, 0, a + 3*S + 2 + L);
      a3 = a + 3*S + L + 3;
      push(1, 0, a3);
      push(2, 0, a3 + S);
      push(2, 1, a3 + 2*S + 1 + L);
      push(1, 1, a3 + 3*S + 1 + L);
      push(4, 1, a3 + 3*S + 1 + L);
      push(4, 0, a3 + 3*S + 2 + L);
      wait_cyc(f);
      chk("fb_rdy", rif.req_ready_o, 0);
      wait_cyc(f + 2);
      lock = 1'b1;
      wait_cyc(a);
      chk("bp_rdy", rif.req_ready_o, 0);
      wait_cyc(a + 3*S + L + 2);
      chk("bp_idle_rdy", rif.req_ready_o, 1);
      wait_cyc(a3);
      rif.req_valid_i = 1'b0;
      chk("bp_rdy2", rif.req_ready_o, 0);
      wait_cyc(a3 + 3*S + L + 5);
      chk("bp_pend", expq.size(), 0);

      // Timeout with lock held low
      a = cyc + 1;
      rif.req_valid_i = 1'b1;
      rif.req_cfg_i   = 3'd2;
      lock = 1'b0;
      t = a + 2*S + 1 + T;
      push(1, 0, a);
      push(2, 0, a + S);
      push(3, 2, a + 2*S);
      push(1, 1, t);
      push(4, 1, t);
      push(5, 1, t);
      push(4, 0, t + 1);
      @(negedge clk);
      rif.req_valid_i = 1'b0;
      wait_cyc(t + 3);
      chk("to_pend", expq.size(), 0);
      chk("to_sel", sel, 0);
      chk("to_gate", gate, 1);
      chk("to_cfg", cfg_o, 2);
      chk("to_err", err, 1);

      // Glitchy lock: 5 high, 1 low, then high
      a = cyc + 1;
      rif.req_valid_i = 1'b1;
      rif.req_cfg_i   = 3'd6;
      push(1, 0, a);
      push(3, 6, a + 2*S);
      push(2, 1, a + 2*S + 7 + L);
      push(1, 1, a + 3*S + 7 + L);
      push(4, 1, a + 3*S + 7 + L);
      push(5, 0, a + 3*S + 7 + L);
      push(4, 0, a + 3*S + 8 + L);
      @(negedge clk);
      rif.req_valid_i = 1'b0;
      wait_cyc(a + 2*S - 1);
      lock = 1'b1;
      wait_cyc(a + 2*S + 4);
      lock = 1'b0;
      wait_cyc(a + 2*S + 5);
      lock = 1'b1;
      wait_cyc(a + 3*S + L + 12);
      chk("gl_pend", expq.size(), 0);

      // Reset while in SWITCH
      a = cyc + 1;
      rif.req_valid_i = 1'b1;
      rif.req_cfg_i   = 3'd1;
      push(1, 0, a);
      push(2, 0, a + S);
      push(3, 1, a + 2*S);
      push(2, 1, a + 2*S + 1 + L);
      @(negedge clk);
      rif.req_valid_i = 1'b0;
      wait_cyc(a + 2*S + 2 + L);
      chk("sw_pend", expq.size(), 0);
      chk("sw_sel", sel, 1);
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("swrst");
      wait_cyc(a + 3*S + L + 6);
      chk("swrst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("post_done", done, 0);
      chk("post_rdy", rif.req_ready_o, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
